// File: rtl/count_evt_pkg.sv
// rtl/count_evt_pkg.sv - shared event codes and record-width helper for the count event monitor
package count_evt_pkg;

  localparam int EVT_TYPE_W = 2;

  localparam logic [EVT_TYPE_W-1:0] EVT_LOAD    = 2'd0;
  localparam logic [EVT_TYPE_W-1:0] EVT_WRAP_UP = 2'd1;
  localparam logic [EVT_TYPE_W-1:0] EVT_WRAP_DN = 2'd2;
  localparam logic [EVT_TYPE_W-1:0] EVT_MATCH   = 2'd3;

  // Record layout is {type, timestamp, value}.
  function automatic int evt_rec_w(input int cnt_w, input int ts_w);
    return EVT_TYPE_W + ts_w + cnt_w;
  endfunction

endpackage

// File: rtl/count_event_monitor_if.sv
// rtl/count_event_monitor_if.sv - valid/ready event record stream between monitor and consumer
interface count_event_monitor_if #(
  parameter int DATA_W = count_evt_pkg::evt_rec_w(64, 32)
);

  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_data;

  modport master (
    output evt_valid,
    output evt_data,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    output evt_ready
  );

endinterface

// File: rtl/count_evt_fifo.sv
// rtl/count_evt_fifo.sv - show-ahead synchronous FIFO with valid/ready pop and flush on reset
module count_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_push_ok,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_count;
  logic             w_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count   = r_wptr - r_rptr;
  assign o_full    = (w_count == CNT_FULL);
  assign o_valid   = (r_wptr != r_rptr);
  assign w_pop     = o_valid & i_ready;
  // A pop in the same cycle frees the slot the incoming push needs.
  assign o_push_ok = i_push & (~o_full | w_pop);
  assign o_data    = o_valid ? r_mem[r_rptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (o_push_ok) begin
      r_mem[r_wptr[AW-1:0]] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (o_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_event_monitor.sv
// rtl/count_event_monitor.sv - samples the counter, detects LOAD/WRAP/MATCH events and queues
// timestamped records, counting events lost while the consumer stalls
module count_event_monitor
  import count_evt_pkg::*;
#(
  parameter int CNT_W      = 64,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        count_in,
  input  logic                    load_in,
  input  logic                    cfg_en,
  input  logic [CNT_W-1:0]        cfg_cmp_value,
  input  logic                    ovf_clr,
  count_event_monitor_if.master   evt_if,
  output logic                    ovf_sticky,
  output logic [15:0]             drop_cnt
);

  localparam int REC_W = evt_rec_w(CNT_W, TS_W);

  logic [CNT_W-1:0]      r_cur;
  logic [CNT_W-1:0]      r_prev;
  logic                  r_load_d;
  logic                  r_cur_valid;
  logic                  r_prev_valid;
  logic [TS_W-1:0]       r_ts;
  logic                  r_ovf_sticky;
  logic [15:0]           r_drop_cnt;

  logic                  w_push;
  logic [EVT_TYPE_W-1:0] w_evt_type;
  logic [REC_W-1:0]      w_rec;
  logic                  w_push_ok;
  logic                  w_full;
  logic                  w_drop;

  // r_cur_valid gates everything so the reset value of r_cur never looks like a sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur        <= '0;
      r_prev       <= '0;
      r_load_d     <= 1'b0;
      r_cur_valid  <= 1'b0;
      r_prev_valid <= 1'b0;
    end else begin
      r_cur        <= count_in;
      r_prev       <= r_cur;
      r_load_d     <= load_in;
      r_cur_valid  <= 1'b1;
      r_prev_valid <= r_cur_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  // Priority chain yields at most one event; lower-priority hits are simply not raised.
  always_comb begin
    w_push     = 1'b0;
    w_evt_type = EVT_LOAD;
    if (cfg_en && r_cur_valid) begin
      if (r_prev_valid && r_load_d) begin
        w_push     = 1'b1;
        w_evt_type = EVT_LOAD;
      end else if (r_prev_valid && (r_prev == '1) && (r_cur == '0)) begin
        w_push     = 1'b1;
        w_evt_type = EVT_WRAP_UP;
      end else if (r_prev_valid && (r_prev == '0) && (r_cur == '1)) begin
        w_push     = 1'b1;
        w_evt_type = EVT_WRAP_DN;
      end else if ((r_cur == cfg_cmp_value) &&
                   (!r_prev_valid || (r_prev != cfg_cmp_value))) begin
        w_push     = 1'b1;
        w_evt_type = EVT_MATCH;
      end
    end
  end

  assign w_rec  = {w_evt_type, r_ts, r_cur};
  assign w_drop = w_push & ~w_push_ok;

  count_evt_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_rec),
    .o_push_ok   (w_push_ok),
    .o_full      (w_full),
    .o_valid     (evt_if.evt_valid),
    .o_data      (evt_if.evt_data),
    .i_ready     (evt_if.evt_ready)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!w_drop || w_full);
    end
  end

  // A drop coinciding with a clear restarts the count at one rather than losing the event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_sticky <= 1'b0;
      r_drop_cnt   <= '0;
    end else if (w_drop) begin
      r_ovf_sticky <= 1'b1;
      if (ovf_clr) begin
        r_drop_cnt <= 16'd1;
      end else if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end else if (ovf_clr) begin
      r_ovf_sticky <= 1'b0;
      r_drop_cnt   <= '0;
    end
  end

  assign ovf_sticky = r_ovf_sticky;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_count_event_monitor.sv
// tb/tb_count_event_monitor.sv - directed scenarios plus randomized run against a queue-based model
module tb_count_event_monitor;
  import count_evt_pkg::*;

  localparam int          REC_W = 98;
  localparam logic [63:0] ONES  = '1;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] count_in;
  logic        load_in;
  logic        cfg_en;
  logic [63:0] cfg_cmp_value;
  logic        ovf_clr;
  logic        ovf_sticky;
  logic [15:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  count_event_monitor_if #(.DATA_W(REC_W)) ev_if ();

  count_event_monitor #(
    .CNT_W      (64),
    .TS_W       (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .count_in      (count_in),
    .load_in       (load_in),
    .cfg_en        (cfg_en),
    .cfg_cmp_value (cfg_cmp_value),
    .ovf_clr       (ovf_clr),
    .evt_if        (ev_if),
    .ovf_sticky    (ovf_sticky),
    .drop_cnt      (drop_cnt)
  );

  // Reference model: sample history, a bounded record queue and drop bookkeeping.
  logic [REC_W-1:0] m_q [$];
  logic             m_ovf;
  int               m_drops;
  logic [31:0]      m_ts;
  logic [63:0]      h_cur, h_prev;
  logic             h_ld;
  int               nsamp;

  always @(posedge clk) begin : model
    logic       ev, drop;
    logic [1:0] t;
    if (reset) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
      m_ts    = '0;
      nsamp   = 0;
    end else begin
      ev = 1'b0;
      t  = 2'd0;
      if (cfg_en && nsamp >= 1) begin
        if (nsamp >= 2 && h_ld) begin
          ev = 1'b1; t = 2'd0;
        end else if (nsamp >= 2 && h_prev == ONES && h_cur == 64'd0) begin
          ev = 1'b1; t = 2'd1;
        end else if (nsamp >= 2 && h_prev == 64'd0 && h_cur == ONES) begin
          ev = 1'b1; t = 2'd2;
        end else if (h_cur == cfg_cmp_value && (nsamp < 2 || h_prev != cfg_cmp_value)) begin
          ev = 1'b1; t = 2'd3;
        end
      end
      if (m_q.size() != 0 && ev_if.evt_ready) void'(m_q.pop_front());
      drop = 1'b0;
      if (ev) begin
        if (m_q.size() < 4) m_q.push_back({t, m_ts, h_cur});
        else drop = 1'b1;
      end
      if (drop) begin
        m_ovf   = 1'b1;
        m_drops = ovf_clr ? 1 : ((m_drops == 65535) ? 65535 : m_drops + 1);
      end else if (ovf_clr) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
      h_prev = h_cur;
      h_cur  = count_in;
      h_ld   = load_in;
      if (nsamp < 2) nsamp++;
      m_ts = m_ts + 32'd1;
    end
  end

  // Records actually handed over, captured after the negedge stimulus has settled.
  logic [REC_W-1:0] got [$];
  always @(negedge clk) begin
    #1;
    if (!reset && ev_if.evt_valid && ev_if.evt_ready) got.push_back(ev_if.evt_data);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [63:0] v, input logic ld);
    count_in = v;
    load_in  = ld;
    cyc(1);
  endtask

  task automatic settle(input logic [63:0] v);
    cfg_en          = 1'b0;
    load_in         = 1'b0;
    ovf_clr         = 1'b0;
    count_in        = v;
    ev_if.evt_ready = 1'b1;
    cyc(6);
    got.delete();
    cfg_en = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(3);
    n_vec++;
    if (ev_if.evt_valid !== 1'b0 || ev_if.evt_data !== '0) begin
      n_err++;
      $display("FAIL reset_evt: valid=%b data=%h want valid=0 data=0", ev_if.evt_valid, ev_if.evt_data);
    end
    n_vec++;
    if (ovf_sticky !== 1'b0 || drop_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_ovf: ovf=%b drop=%0d want 0/0", ovf_sticky, drop_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap_up();
    logic [31:0] d;
    cfg_cmp_value = 64'h5555;
    settle(64'd5);
    drive(ONES - 64'd1, 1'b1);
    drive(ONES, 1'b0);
    drive(64'd0, 1'b0);
    n_vec++;
    if (ev_if.evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_early: valid=%b want 0", ev_if.evt_valid);
    end
    drive(64'd1, 1'b0);
    n_vec++;
    if (ev_if.evt_valid !== 1'b1 || ev_if.evt_data[97:96] !== EVT_WRAP_UP || ev_if.evt_data[63:0] !== 64'd0) begin
      n_err++;
      $display("FAIL wrap_latency: valid=%b data=%h want valid=1 type=1 value=0", ev_if.evt_valid, ev_if.evt_data);
    end
    cyc(3);
    n_vec++;
    if (got.size() != 2) begin
      n_err++;
      $display("FAIL wrap_count: got %0d records want 2", got.size());
    end else begin
      d = got[1][95:64] - got[0][95:64];
      n_vec++;
      if (got[0][97:96] !== EVT_LOAD || got[0][63:0] !== ONES - 64'd1 || got[1][97:96] !== EVT_WRAP_UP || d !== 32'd2) begin
        n_err++;
        $display("FAIL wrap_records: r0=%h r1=%h ts_diff=%0d want LOAD ..FE, WRAP_UP 0, diff 2", got[0], got[1], d);
      end
    end
  endtask

  task automatic test_match();
    logic [63:0]      seq [9] = '{64'd8, 64'd9, 64'd10, 64'd11, 64'd12, 64'd11, 64'd10, 64'd9, 64'd8};
    logic [1:0]       et  [3] = '{EVT_LOAD, EVT_MATCH, EVT_MATCH};
    logic [63:0]      evv [3] = '{64'd8, 64'd10, 64'd10};
    logic [REC_W-1:0] r;
    cfg_cmp_value = 64'd10;
    settle(64'd100);
    for (int i = 0; i < 9; i++) drive(seq[i], i == 0);
    cyc(4);
    n_vec++;
    if (got.size() != 3) begin
      n_err++;
      $display("FAIL match_count: got %0d records want 3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      r = (i < got.size()) ? got[i] : 'x;
      n_vec++;
      if (r[97:96] !== et[i] || r[63:0] !== evv[i]) begin
        n_err++;
        $display("FAIL match_rec%0d: got %h want type=%0d value=%0d", i, r, et[i], evv[i]);
      end
    end
  endtask

  task automatic test_load_wrap_dn();
    logic [1:0]       et  [3] = '{EVT_LOAD, EVT_LOAD, EVT_WRAP_DN};
    logic [63:0]      evv [3];
    logic [REC_W-1:0] r;
    evv = '{64'd10, 64'd0, ONES};
    cfg_cmp_value = 64'd10;
    settle(64'd50);
    drive(64'd10, 1'b1);
    drive(64'd10, 1'b0);
    drive(64'd10, 1'b0);
    drive(64'd0, 1'b1);
    drive(ONES, 1'b0);
    drive(ONES - 64'd1, 1'b0);
    cyc(4);
    n_vec++;
    if (got.size() != 3) begin
      n_err++;
      $display("FAIL ldwd_count: got %0d records want 3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      r = (i < got.size()) ? got[i] : 'x;
      n_vec++;
      if (r[97:96] !== et[i] || r[63:0] !== evv[i]) begin
        n_err++;
        $display("FAIL ldwd_rec%0d: got %h want type=%0d value=%h", i, r, et[i], evv[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [REC_W-1:0] r;
    cfg_cmp_value = 64'd10;
    settle(64'd100);
    ev_if.evt_ready = 1'b0;
    for (int i = 1; i <= 6; i++) drive(64'(i), 1'b1);
    load_in = 1'b0;
    cyc(3);
    n_vec++;
    if (ovf_sticky !== 1'b1 || drop_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL ovf_drops: ovf=%b drop=%0d want 1/2", ovf_sticky, drop_cnt);
    end
    n_vec++;
    if (ev_if.evt_valid !== 1'b1 || ev_if.evt_data[63:0] !== 64'd1) begin
      n_err++;
      $display("FAIL ovf_head: valid=%b data=%h want valid=1 value=1", ev_if.evt_valid, ev_if.evt_data);
    end
    got.delete();
    ev_if.evt_ready = 1'b1;
    cyc(6);
    n_vec++;
    if (got.size() != 4) begin
      n_err++;
      $display("FAIL ovf_drain_count: got %0d want 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      r = (i < got.size()) ? got[i] : 'x;
      n_vec++;
      if (r[97:96] !== EVT_LOAD || r[63:0] !== 64'(i + 1)) begin
        n_err++;
        $display("FAIL ovf_drain%0d: got %h want LOAD value %0d", i, r, i + 1);
      end
    end
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    n_vec++;
    if (ovf_sticky !== 1'b0 || drop_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL ovf_clr: ovf=%b drop=%0d want 0/0", ovf_sticky, drop_cnt);
    end
  endtask

  task automatic test_full_pop_push();
    logic [REC_W-1:0] r;
    cfg_cmp_value = 64'd10;
    settle(64'd100);
    ev_if.evt_ready = 1'b0;
    for (int i = 1; i <= 4; i++) drive(64'(i), 1'b1);
    load_in = 1'b0;
    cyc(2);
    drive(64'd5, 1'b1);
    load_in = 1'b0;
    ev_if.evt_ready = 1'b1;
    cyc(1);
    ev_if.evt_ready = 1'b0;
    cyc(1);
    n_vec++;
    if (drop_cnt !== 16'd0 || ovf_sticky !== 1'b0 || ev_if.evt_data[63:0] !== 64'd2) begin
      n_err++;
      $display("FAIL full_pop_push: drop=%0d ovf=%b head=%h want 0/0 head value 2", drop_cnt, ovf_sticky, ev_if.evt_data);
    end
    drive(64'd6, 1'b1);
    drive(64'd7, 1'b1);
    load_in = 1'b0;
    cyc(2);
    n_vec++;
    if (drop_cnt !== 16'd2 || ovf_sticky !== 1'b1) begin
      n_err++;
      $display("FAIL full_drops: drop=%0d ovf=%b want 2/1", drop_cnt, ovf_sticky);
    end
    drive(64'd8, 1'b1);
    load_in = 1'b0;
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    n_vec++;
    if (drop_cnt !== 16'd1 || ovf_sticky !== 1'b1) begin
      n_err++;
      $display("FAIL clr_vs_drop: drop=%0d ovf=%b want 1/1", drop_cnt, ovf_sticky);
    end
    got.delete();
    ev_if.evt_ready = 1'b1;
    cyc(6);
    for (int i = 0; i < 4; i++) begin
      r = (i < got.size()) ? got[i] : 'x;
      n_vec++;
      if (r[63:0] !== 64'(i + 2)) begin
        n_err++;
        $display("FAIL full_order%0d: got %h want value %0d", i, r, i + 2);
      end
    end
  endtask

  task automatic test_reset_flush();
    cfg_cmp_value = 64'd10;
    ev_if.evt_ready = 1'b0;
    drive(64'd1, 1'b1);
    drive(64'd2, 1'b1);
    drive(64'd3, 1'b1);
    load_in  = 1'b0;
    count_in = ONES;
    cyc(2);
    n_vec++;
    if (ev_if.evt_valid !== 1'b1 || drop_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL flush_pre: valid=%b drop=%0d want 1/1", ev_if.evt_valid, drop_cnt);
    end
    got.delete();
    reset = 1'b1;
    cyc(1);
    n_vec++;
    if (ev_if.evt_valid !== 1'b0 || drop_cnt !== 16'd0 || ovf_sticky !== 1'b0) begin
      n_err++;
      $display("FAIL flush_reset: valid=%b drop=%0d ovf=%b want 0/0/0", ev_if.evt_valid, drop_cnt, ovf_sticky);
    end
    reset           = 1'b0;
    count_in        = 64'd0;
    ev_if.evt_ready = 1'b1;
    cyc(5);
    n_vec++;
    if (got.size() != 0) begin
      n_err++;
      $display("FAIL flush_no_wrap: got %0d records want 0", got.size());
    end
  endtask

  task automatic test_random();
    logic [63:0]      c = 64'd3;
    logic [REC_W-1:0] exp_d;
    logic             exp_v;
    int               r;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        r = $urandom_range(0, 3);
        cfg_cmp_value = (r == 0) ? 64'd7 : (r == 1) ? ONES : (r == 2) ? 64'd0 : {32'd0, $urandom};
      end
      load_in = 1'b0;
      r = $urandom_range(0, 15);
      if (r == 0) begin
        load_in = 1'b1;
        case ($urandom_range(0, 3))
          0:       c = 64'd0;
          1:       c = ONES;
          2:       c = cfg_cmp_value - 64'd1;
          default: c = {$urandom, $urandom};
        endcase
      end else if (r <= 7) begin
        c = c + 64'd1;
      end else if (r <= 13) begin
        c = c - 64'd1;
      end
      count_in        = c;
      cfg_en          = ($urandom_range(0, 15) != 0);
      ev_if.evt_ready = ((i % 64) < 40) ? ($urandom_range(0, 2) != 0) : 1'b0;
      ovf_clr         = ($urandom_range(0, 31) == 0);
      reset           = ($urandom_range(0, 499) == 0);
      cyc(1);
      exp_v = (m_q.size() != 0);
      exp_d = exp_v ? m_q[0] : '0;
      n_vec++;
      if (ev_if.evt_valid !== exp_v || ev_if.evt_data !== exp_d) begin
        n_err++;
        $display("FAIL rand_evt cyc %0d: valid=%b data=%h want valid=%b data=%h", i, ev_if.evt_valid, ev_if.evt_data, exp_v, exp_d);
      end
      n_vec++;
      if (ovf_sticky !== m_ovf || drop_cnt !== m_drops[15:0]) begin
        n_err++;
        $display("FAIL rand_ovf cyc %0d: ovf=%b drop=%0d want %b/%0d", i, ovf_sticky, drop_cnt, m_ovf, m_drops);
      end
    end
    reset   = 1'b0;
    ovf_clr = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    count_in        = '0;
    load_in         = 1'b0;
    cfg_en          = 1'b0;
    cfg_cmp_value   = 64'h5555;
    ovf_clr         = 1'b0;
    ev_if.evt_ready = 1'b0;
    test_reset();
    test_wrap_up();
    test_match();
    test_load_wrap_dn();
    test_overflow();
    test_full_pop_push();
    test_reset_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
